// File: rtl/ex_muldiv.sv
// Execute stage: combinational ALU path plus an iterative multiply/divide unit
// with a valid/over/go handshake toward the pipeline controller.

module alu #(
    parameter int unsigned XLEN = 32
) (
    input  logic [11:0]     i_aluop,
    input  logic [XLEN-1:0] i_src1,
    input  logic [XLEN-1:0] i_src2,
    output logic [XLEN-1:0] o_result
);
    localparam int unsigned SHW = $clog2(XLEN);

    logic [SHW-1:0] w_shamt;
    assign w_shamt = i_src2[SHW-1:0];

    // One-hot aluop: add sub slt sltu and nor or xor sll srl sra lui
    always_comb begin
        o_result = '0;
        if (i_aluop[0])  o_result = o_result | (i_src1 + i_src2);
        if (i_aluop[1])  o_result = o_result | (i_src1 - i_src2);
        if (i_aluop[2])  o_result = o_result | XLEN'($signed(i_src1) < $signed(i_src2));
        if (i_aluop[3])  o_result = o_result | XLEN'(i_src1 < i_src2);
        if (i_aluop[4])  o_result = o_result | (i_src1 & i_src2);
        if (i_aluop[5])  o_result = o_result | ~(i_src1 | i_src2);
        if (i_aluop[6])  o_result = o_result | (i_src1 | i_src2);
        if (i_aluop[7])  o_result = o_result | (i_src1 ^ i_src2);
        if (i_aluop[8])  o_result = o_result | (i_src1 << w_shamt);
        if (i_aluop[9])  o_result = o_result | (i_src1 >> w_shamt);
        if (i_aluop[10]) o_result = o_result | XLEN'($signed(i_src1) >>> w_shamt);
        if (i_aluop[11]) o_result = o_result | i_src2;
    end
endmodule

module ex_muldiv #(
    parameter int unsigned XLEN       = 32,
    parameter int unsigned ADDR_W     = 5,
    parameter int unsigned MUL_CYCLES = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [4*XLEN+ADDR_W+22:0]  id2ex_bus_ri,
    output logic [3*XLEN+ADDR_W+6:0]   ex2mem_bus_o,
    input  logic                       ctl_ex_valid_i,
    input  logic                       ctl_ex_go_i,
    input  logic                       ctl_ex_flush_i,
    output logic                       ctl_ex_over_o,
    output logic [ADDR_W-1:0]          ctl_ex_dest_o,
    output logic                       ctl_ex_busy_o
);
    localparam int unsigned K     = XLEN / MUL_CYCLES;
    localparam int unsigned ACC_W = 2 * XLEN;
    localparam int unsigned PP_W  = XLEN + K;
    localparam int unsigned CNT_W = $clog2(XLEN);

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV, S_DONE} state_t;

    state_t r_state, w_state_nx;

    logic [3:0]        w_md_op;
    logic [11:0]       w_aluop;
    logic [XLEN-1:0]   w_rj, w_rk, w_st_data, w_pc, w_alu_res;
    logic [5:0]        w_mem_ctl;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              w_rd_we;

    assign {w_md_op, w_aluop, w_rj, w_rk, w_mem_ctl, w_st_data, w_rd_addr, w_rd_we, w_pc} = id2ex_bus_ri;

    alu #(.XLEN(XLEN)) u_alu (
        .i_aluop  (w_aluop),
        .i_src1   (w_rj),
        .i_src2   (w_rk),
        .o_result (w_alu_res)
    );

    // Op decode: 1xxx aliases to the ALU path
    logic [2:0] w_md;
    logic       w_is_mul, w_is_div, w_sgn, w_accept;
    logic [XLEN-1:0] w_abs_j, w_abs_k;

    assign w_md     = w_md_op[3] ? 3'd0 : w_md_op[2:0];
    assign w_is_mul = (w_md != 3'd0) && !w_md[2];
    assign w_is_div = w_md[2];
    assign w_sgn    = w_is_mul ? (w_md != 3'd3) : !w_md[1];
    assign w_accept = ctl_ex_valid_i && !ctl_ex_flush_i && (r_state == S_IDLE);
    assign w_abs_j  = (w_sgn && w_rj[XLEN-1]) ? -w_rj : w_rj;
    assign w_abs_k  = (w_sgn && w_rk[XLEN-1]) ? -w_rk : w_rk;

    logic [XLEN-1:0]  r_opd;      // multiplicand for MUL, divisor for DIV
    logic [ACC_W-1:0] r_acc;      // {hi product | remainder, multiplier | quotient}
    logic [CNT_W-1:0] r_cnt;
    logic [XLEN-1:0]  r_result;
    logic             r_neg, r_rneg;
    logic [1:0]       r_sel;      // 0 mul lo, 1 mul hi, 2 quotient, 3 remainder

    // Shift-add step: add K bits worth of partial product, then shift right by K
    logic [PP_W-1:0]       w_pp, w_sum;
    logic [ACC_W+K-1:0]    w_cat;
    logic [ACC_W-1:0]      w_mul_next, w_prod;

    assign w_pp       = PP_W'(r_opd) * PP_W'(r_acc[K-1:0]);
    assign w_sum      = PP_W'(r_acc[ACC_W-1:XLEN]) + w_pp;
    assign w_cat      = {w_sum, r_acc[XLEN-1:0]};
    assign w_mul_next = ACC_W'(w_cat >> K);
    assign w_prod     = r_neg ? -w_mul_next : w_mul_next;

    // Restoring division step, one quotient bit per cycle
    logic [XLEN:0]      w_shift, w_diff;
    logic [ACC_W-1:0]   w_div_next;
    logic [XLEN-1:0]    w_quo, w_rem;

    assign w_shift    = {r_acc[ACC_W-1:XLEN], r_acc[XLEN-1]};
    assign w_diff     = w_shift - {1'b0, r_opd};
    assign w_div_next = w_diff[XLEN] ? {w_shift[XLEN-1:0], r_acc[XLEN-2:0], 1'b0}
                                     : {w_diff[XLEN-1:0],  r_acc[XLEN-2:0], 1'b1};
    assign w_quo      = r_neg  ? -w_div_next[XLEN-1:0]     : w_div_next[XLEN-1:0];
    assign w_rem      = r_rneg ? -w_div_next[ACC_W-1:XLEN] : w_div_next[ACC_W-1:XLEN];

    logic w_mul_last, w_div_last;
    assign w_mul_last = (r_cnt == CNT_W'(MUL_CYCLES - 1));
    assign w_div_last = (r_cnt == CNT_W'(XLEN - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept && w_is_mul)                    w_state_nx = S_MUL;
                else if (w_accept && w_is_div && w_rk != '0) w_state_nx = S_DIV;
                else if (w_accept && w_is_div)               w_state_nx = S_DONE;
            end
            S_MUL:   if (w_mul_last)  w_state_nx = S_DONE;
            S_DIV:   if (w_div_last)  w_state_nx = S_DONE;
            S_DONE:  if (ctl_ex_go_i) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
        if (ctl_ex_flush_i) w_state_nx = S_IDLE;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_opd    <= '0;
            r_acc    <= '0;
            r_cnt    <= '0;
            r_result <= '0;
            r_neg    <= 1'b0;
            r_rneg   <= 1'b0;
            r_sel    <= 2'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_accept && (w_is_mul || w_is_div)) begin
                        r_cnt  <= '0;
                        r_neg  <= w_sgn && (w_rj[XLEN-1] ^ w_rk[XLEN-1]);
                        r_rneg <= w_sgn && w_rj[XLEN-1];
                        r_sel  <= w_is_div ? {1'b1, w_md[0]} : {1'b0, w_md != 3'd1};
                        r_opd  <= w_is_div ? w_abs_k : w_abs_j;
                        r_acc  <= {{XLEN{1'b0}}, (w_is_div ? w_abs_j : w_abs_k)};
                        // Divide by zero resolves immediately
                        if (w_is_div && w_rk == '0)
                            r_result <= w_md[0] ? w_rj : '1;
                    end
                end
                S_MUL: begin
                    r_acc <= w_mul_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_mul_last && !ctl_ex_flush_i)
                        r_result <= r_sel[0] ? w_prod[ACC_W-1:XLEN] : w_prod[XLEN-1:0];
                end
                S_DIV: begin
                    r_acc <= w_div_next;
                    r_cnt <= r_cnt + CNT_W'(1);
                    if (w_div_last && !ctl_ex_flush_i)
                        r_result <= r_sel[0] ? w_rem : w_quo;
                end
                default: ;
            endcase
        end
    end

    logic [XLEN-1:0] w_result;
    assign w_result = (r_state == S_IDLE) ? w_alu_res : r_result;

    assign ex2mem_bus_o  = {w_mem_ctl, w_st_data, w_result, w_rd_addr, w_rd_we, w_pc};
    assign ctl_ex_dest_o = w_rd_addr & {ADDR_W{ctl_ex_valid_i}};
    assign ctl_ex_busy_o = !rst && (r_state != S_IDLE);

    // Handshake: ALU ops complete in the arrival cycle, md ops only from DONE
    always_comb begin
        ctl_ex_over_o = 1'b0;
        if (!rst) begin
            if (r_state == S_IDLE)
                ctl_ex_over_o = ctl_ex_valid_i && !(w_is_mul || w_is_div);
            else
                ctl_ex_over_o = (r_state == S_DONE) && !ctl_ex_flush_i;
        end
    end
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: ALU path, multiply/divide results and latency,
// divide-by-zero, overflow, stall in DONE, flush and mid-operation reset.

module tb_ex_muldiv;
    localparam int unsigned XLEN   = 32;
    localparam int unsigned ADDR_W = 5;

    logic                      clk = 1'b0;
    logic                      rst;
    logic [4*XLEN+ADDR_W+22:0] id2ex;
    logic [3*XLEN+ADDR_W+6:0]  ex2mem;
    logic                      valid, go, flush;
    logic                      over, busy;
    logic [ADDR_W-1:0]         dest;

    logic [5:0]        b_mem_ctl;
    logic [XLEN-1:0]   b_st, b_result, b_pc;
    logic [ADDR_W-1:0] b_rd;
    logic              b_we;

    int n_checks = 0;
    int n_err    = 0;

    localparam logic [11:0] OP_ADD = 12'h001;
    localparam logic [3:0]  MD_ALU = 4'd0, MD_MUL = 4'd1, MD_MULH = 4'd2, MD_MULHU = 4'd3,
                            MD_DIV = 4'd4, MD_MOD = 4'd5, MD_DIVU = 4'd6, MD_MODU = 4'd7;

    always #5 clk = ~clk;

    assign {b_mem_ctl, b_st, b_result, b_rd, b_we, b_pc} = ex2mem;

    ex_muldiv #(.XLEN(XLEN), .ADDR_W(ADDR_W), .MUL_CYCLES(4)) dut (
        .clk            (clk),
        .rst            (rst),
        .id2ex_bus_ri   (id2ex),
        .ex2mem_bus_o   (ex2mem),
        .ctl_ex_valid_i (valid),
        .ctl_ex_go_i    (go),
        .ctl_ex_flush_i (flush),
        .ctl_ex_over_o  (over),
        .ctl_ex_dest_o  (dest),
        .ctl_ex_busy_o  (busy)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] md, input logic [11:0] aop,
                         input logic [31:0] a, input logic [31:0] b);
        valid = v;
        id2ex = {md, aop, a, b, 6'h15, 32'hCAFE0000, 5'd3, 1'b1, 32'h1C000040};
    endtask

    // Issue an md op between edges, check latency, result and return to IDLE
    task automatic run_md(input string tag, input logic [3:0] md, input logic [31:0] a,
                          input logic [31:0] b, input int lat, input logic [31:0] exp);
        drive(1'b1, md, 12'h000, a, b);
        #1;
        chk({tag, "_over_T"}, 32'(over), 32'd0);
        for (int i = 1; i < lat; i++) begin
            @(posedge clk); #2;
            chk({tag, "_over_wait"}, 32'(over), 32'd0);
            chk({tag, "_busy_wait"}, 32'(busy), 32'd1);
        end
        @(posedge clk); #2;
        chk({tag, "_over_done"}, 32'(over), 32'd1);
        chk({tag, "_result"}, b_result, exp);
        go = 1'b1;
        @(posedge clk); #1;
        go    = 1'b0;
        valid = 1'b0;
        #1;
        chk({tag, "_busy_after_go"}, 32'(busy), 32'd0);
    endtask

    initial begin
        rst   = 1'b1;
        go    = 1'b0;
        flush = 1'b0;
        drive(1'b0, MD_ALU, 12'h000, 32'd0, 32'd0);
        @(posedge clk); #2;
        chk("rst_over", 32'(over), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        #1;
        chk("idle_busy", 32'(busy), 32'd0);
        chk("idle_dest", 32'(dest), 32'd0);

        // ADD completes combinationally
        @(posedge clk); #1;
        drive(1'b1, MD_ALU, OP_ADD, 32'd5, 32'd7);
        #1;
        chk("add_over", 32'(over), 32'd1);
        chk("add_result", b_result, 32'd12);
        chk("add_busy", 32'(busy), 32'd0);
        chk("add_dest", 32'(dest), 32'd3);
        chk("add_pc", b_pc, 32'h1C000040);
        chk("add_st", b_st, 32'hCAFE0000);
        @(posedge clk); #1;
        valid = 1'b0;

        // MUL.W with go held off three cycles in DONE
        @(posedge clk); #1;
        drive(1'b1, MD_MUL, 12'h000, 32'd7, 32'hFFFFFFFD);
        #1;
        chk("mul_over_T", 32'(over), 32'd0);
        for (int i = 1; i < 5; i++) begin
            @(posedge clk); #2;
            chk("mul_over_wait", 32'(over), 32'd0);
            chk("mul_dest_wait", 32'(dest), 32'd3);
        end
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            if (i == 3) go = 1'b1;
            #1;
            chk("mul_over_hold", 32'(over), 32'd1);
            chk("mul_result_hold", b_result, 32'hFFFFFFEB);
            chk("mul_busy_hold", 32'(busy), 32'd1);
        end
        @(posedge clk); #1;
        go    = 1'b0;
        valid = 1'b0;
        #1;
        chk("mul_busy_after_go", 32'(busy), 32'd0);

        @(posedge clk); #1;
        run_md("mulh",  MD_MULH,  32'h80000000, 32'h80000000, 5,  32'h40000000);
        run_md("mulhu", MD_MULHU, 32'hFFFFFFFF, 32'hFFFFFFFF, 5,  32'hFFFFFFFE);
        run_md("mulh_mix", MD_MULH, 32'hFFFFFFFF, 32'd2,      5,  32'hFFFFFFFF);
        run_md("div",   MD_DIV,   32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFD);
        run_md("mod",   MD_MOD,   32'hFFFFFFF9, 32'd2,        33, 32'hFFFFFFFF);
        run_md("div_ovf", MD_DIV, 32'h80000000, 32'hFFFFFFFF, 33, 32'h80000000);
        run_md("mod_ovf", MD_MOD, 32'h80000000, 32'hFFFFFFFF, 33, 32'h00000000);
        run_md("divu",  MD_DIVU,  32'd100,      32'd7,        33, 32'd14);
        run_md("modu",  MD_MODU,  32'd100,      32'd7,        33, 32'd2);
        run_md("divu0", MD_DIVU,  32'd5,        32'd0,        1,  32'hFFFFFFFF);
        run_md("modu0", MD_MODU,  32'd5,        32'd0,        1,  32'd5);
        run_md("mod0_s", MD_MOD,  32'hFFFFFFF9, 32'd0,        1,  32'hFFFFFFF9);

        // Flush at T+10 abandons a DIV; ADD completes in its first cycle
        @(posedge clk); #1;
        drive(1'b1, MD_DIV, 12'h000, 32'd1000, 32'd3);
        for (int i = 1; i < 10; i++) begin
            @(posedge clk); #2;
            chk("flush_pre_over", 32'(over), 32'd0);
        end
        @(posedge clk); #1;
        flush = 1'b1;
        go    = 1'b1;
        #1;
        chk("flush_over", 32'(over), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0;
        go    = 1'b0;
        #1;
        chk("flush_idle", 32'(busy), 32'd0);
        drive(1'b1, MD_ALU, OP_ADD, 32'd20, 32'd22);
        #1;
        chk("post_flush_add_over", 32'(over), 32'd1);
        chk("post_flush_add_res", b_result, 32'd42);
        chk("flush_result_kept", dut.r_result, 32'hFFFFFFF9);

        // Reset mid-DIV
        @(posedge clk); #1;
        drive(1'b1, MD_DIV, 12'h000, 32'd1000, 32'd3);
        for (int i = 0; i < 5; i++) @(posedge clk);
        #2;
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("rst_mid_busy", 32'(busy), 32'd0);
        chk("rst_mid_over", 32'(over), 32'd0);
        chk("rst_mid_result", dut.r_result, 32'd0);
        @(posedge clk); #1;
        valid = 1'b0;
        rst   = 1'b0;
        #1;
        chk("post_rst_busy", 32'(busy), 32'd0);

        @(posedge clk); #1;
        run_md("mul_after_rst", MD_MUL, 32'd123, 32'd456, 5, 32'd56088);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule

// File: doc/ex_muldiv.md
# ex_muldiv

Parametrised execute stage for the 5-stage LoongArch pipeline, the successor to the single-cycle ALU-only `ex` stage. Single-cycle ALU operations still complete combinationally in the cycle they arrive. The stage adds an iterative multiply/divide unit (MUL.W, MULH.W[U], DIV.W[U], MOD.W[U]) with a valid/over/go handshake that stalls the pipeline controller for multi-cycle operations, and a flush input that cancels an in-flight operation. It sits between the ID→EX and EX→MEM pipeline registers and reuses the existing `alu` submodule unchanged.

## Interface
Parameters:
- XLEN, 32: datapath width (rj, rk, pc, result).
- ADDR_W, 5: register address width.
- MUL_CYCLES, 4: multiply iterations. Must divide XLEN: 1, 2, 4, 8, 16 or 32. Each iteration consumes XLEN/MUL_CYCLES multiplier bits.

Ports. Clock and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  stage clock.
- rst  in  1  asynchronous, active-high reset.
- id2ex_bus_ri  in  4*XLEN+ADDR_W+23  fields MSB→LSB: {md_op[3:0], aluop[11:0], rj, rk, mem_ctl[5:0], mem_st_data, rd_addr, rd_we, pc}.
- ex2mem_bus_o  out  3*XLEN+ADDR_W+7  fields: {mem_ctl, mem_st_data, result, rd_addr, rd_we, pc}.
- ctl_ex_valid_i  in  1  the EX stage holds a valid instruction. The bus is stable while valid is high and over is low.
- ctl_ex_go_i  in  1  the downstream EX→MEM register captures this cycle.
- ctl_ex_flush_i  in  1  cancel the current instruction.
- ctl_ex_over_o  out  1  the EX result is ready.
- ctl_ex_dest_o  out  ADDR_W  rd_addr & {ADDR_W{ctl_ex_valid_i}}, used for hazard detection.
- ctl_ex_busy_o  out  1  state ≠ IDLE.

## Operation
- md_op encoding:
  - 0000: ALU operation.
  - 0001: MUL.W, low XLEN bits of the signed product.
  - 0010: MULH.W, high XLEN bits of the signed product.
  - 0011: MULH.WU, high XLEN bits of the unsigned product.
  - 0100: DIV.W. 0101: MOD.W. 0110: DIV.WU. 0111: MOD.WU.
  - 1xxx: treated as 0000.
- ALU path (md_op=0000):
  - result = alu(aluop, rj, rk).
  - ctl_ex_over_o = ctl_ex_valid_i, combinationally.
  - The FSM stays in IDLE.
- FSM states IDLE, MUL, DIV, DONE:
  - IDLE → MUL when valid, md_op is a multiply, and no flush. Latch |rj|, |rk| (magnitude for signed ops, raw for unsigned ops), the result sign, the op, and clear the iteration counter.
  - IDLE → DIV, same conditions for a divide with rk≠0.
  - IDLE → DONE directly for a divide with rk=0. Quotient = all ones. Remainder = rj (unmodified).
  - MUL → DONE after MUL_CYCLES iterations. Each iteration is a shift-add of XLEN/MUL_CYCLES bits into a 2*XLEN accumulator.
  - DIV → DONE after XLEN iterations of restoring division, one quotient bit per cycle.
  - Sign correction is applied when writing the result register on the final iteration:
    - Product is negated if the operand signs differ.
    - Quotient is negated if the signs differ.
    - Remainder takes the sign of the dividend.
  - Signed overflow is explicit: INT_MIN / −1 gives quotient INT_MIN, remainder 0.
  - DONE → IDLE when ctl_ex_go_i=1. Otherwise DONE holds, and the result and over stay stable.
- In MUL, DIV or DONE, ctl_ex_over_o = (state==DONE). ex2mem result field = result register.
- All non-result bus fields pass straight through from id2ex_bus_ri.
- Flush: ctl_ex_flush_i=1 forces the next state to IDLE from any state.
  - ctl_ex_over_o is 0 in the flush cycle for md ops.
  - The result register is not updated.
- Reset:
  - state=IDLE, counter=0, result register=0.
  - ctl_ex_over_o and ctl_ex_busy_o are forced 0 while rst is high.
  - A reset mid-operation abandons the operation.

## Timing
- ALU op: 0-cycle latency; over is high in the same cycle as valid.
- The md op accept cycle is T (valid, IDLE).
- MUL: over first high at T+MUL_CYCLES+1.
- DIV: over first high at T+XLEN+1.
- Divide by zero: over first high at T+1.
- The go cycle is the last cycle of over; state is IDLE in the following cycle. Back-to-back md ops therefore accept no earlier than go+1.
- The controller must keep the bus stable from T until go. Changing the bus mid-operation does not alter the latched operands.
- Flush and go asserted in the same cycle: flush wins, and the cycle still counts as the final cycle (IDLE next).
- ctl_ex_dest_o stays valid throughout a multi-cycle op, so consumers stall on the hazard.

## Test plan
- ADD with rj=5, rk=7, valid for 1 cycle → over=1 in the same cycle, result=12, busy=0.
- MUL.W rj=7, rk=0xFFFFFFFD, MUL_CYCLES=4, accepted at T → over first at T+5, result=0xFFFFFFEB. MULH.W 0x80000000×0x80000000 → 0x40000000. MULH.WU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV.W rj=0xFFFFFFF9 (−7), rk=2 → over at T+33, result=0xFFFFFFFD. MOD.W on the same operands → 0xFFFFFFFF. DIV.W 0x80000000/0xFFFFFFFF → 0x80000000, and MOD.W → 0.
- DIV.WU 5/0 → over at T+1, result=0xFFFFFFFF. MOD.WU 5/0 → 5.
- DIV.W started at T, flush at T+10 → over never asserts, state IDLE at T+11. A following ADD completes in its first cycle.
- MUL completes with go held 0 for 3 cycles → over and result stable for 4 cycles, IDLE after go. Assert rst mid-DIV → busy=0 and over=0 immediately, result register=0.
